sample_pipe_stall: RTL and testbench

//   Parametrised successor to the fixed two-stage sample pipeline.
//   - Carries a WIDTH-bit datum through STAGES register stages using a valid/ready handshake,

---
 rtl/sample_pipe_stall.sv | 89 ++++++++
 tb/tb_sample_pipe_stall.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sample_pipe_stall.sv
// Valid/ready sample pipeline with STAGES register stages, bubble collapse and an occupancy count.
// MODE 0 emits CONST_VALUE; MODE 1 emits in + CONST_VALUE (mod 2^WIDTH).
module sample_pipe_stall #(
    parameter int               WIDTH       = 32,
    parameter int               STAGES      = 2,
    parameter int               MODE        = 0,
    parameter logic [WIDTH-1:0] CONST_VALUE = WIDTH'(42)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          input_valid,
    output logic                          input_ready,
    input  logic [WIDTH-1:0]              in,
    output logic                          output_valid,
    input  logic                          output_ready,
    output logic [WIDTH-1:0]              out,
    output logic [$clog2(STAGES+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(STAGES+1);

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] rdy;
    logic [WIDTH-1:0]  data [STAGES];
    logic [WIDTH-1:0]  f_in;
    logic              chain;
    logic              xfer_in;
    logic              xfer_out;
    logic              unused_in;

    // In MODE 0 the datum input is deliberately ignored.
    assign unused_in = ^in;

    always_comb begin
        f_in = (MODE == 1) ? (in + CONST_VALUE) : CONST_VALUE;
    end

    // A stage can load when it is empty or the stage ahead of it is moving.
    always_comb begin
        chain = output_ready;
        rdy   = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            chain  = ~v[i] | chain;
            rdy[i] = chain;
        end
    end

    assign input_ready  = rdy[0];
    assign output_valid = v[STAGES-1];
    assign out          = data[STAGES-1];
    assign xfer_in      = input_valid & rdy[0];
    assign xfer_out     = v[STAGES-1] & output_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data[i] <= '0;
            end
        end else begin
            if (rdy[0]) begin
                v[0] <= input_valid;
                if (input_valid) begin
                    data[0] <= f_in;
                end
            end
            for (int i = 1; i < STAGES; i++) begin
                if (rdy[i]) begin
                    v[i] <= v[i-1];
                    if (v[i-1]) begin
                        data[i] <= data[i-1];
                    end
                end
            end
        end
    end

    // Occupancy tracks popcount(v) without an adder tree over the valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy <= '0;
        end else if (xfer_in && !xfer_out) begin
            occupancy <= occupancy + OCC_W'(1);
        end else if (!xfer_in && xfer_out) begin
            occupancy <= occupancy - OCC_W'(1);
        end
    end

endmodule

// File: tb/tb_sample_pipe_stall.sv
// Self-checking bench for sample_pipe_stall: directed vector table, hand-written
// corner sequences and a random handshake run against a queue scoreboard.
module tb_sample_pipe_stall;

    typedef struct {
        logic        valid;
        logic        ready;
        logic [31:0] din;
        logic        ov;
        logic [31:0] dout;
        logic [1:0]  occ;
        logic        ir;
    } vec_t;

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // MODE 0, STAGES 2
    logic        v2, or2, ir2, ov2;
    logic [31:0] in2, out2;
    logic [1:0]  occ2;
    // MODE 1, STAGES 3
    logic        v3, or3, ir3, ov3;
    logic [31:0] in3, out3;
    logic [1:0]  occ3;
    // MODE 1, WIDTH 8
    logic        v8, or8, ir8, ov8;
    logic [7:0]  in8, out8;
    logic [1:0]  occ8;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    sample_pipe_stall #(.WIDTH(32), .STAGES(2), .MODE(0), .CONST_VALUE(32'd42)) dut2 (
        .clk(clk), .rst(rst), .input_valid(v2), .input_ready(ir2), .in(in2),
        .output_valid(ov2), .output_ready(or2), .out(out2), .occupancy(occ2));

    sample_pipe_stall #(.WIDTH(32), .STAGES(3), .MODE(1), .CONST_VALUE(32'd42)) dut3 (
        .clk(clk), .rst(rst), .input_valid(v3), .input_ready(ir3), .in(in3),
        .output_valid(ov3), .output_ready(or3), .out(out3), .occupancy(occ3));

    sample_pipe_stall #(.WIDTH(8), .STAGES(2), .MODE(1), .CONST_VALUE(8'h10)) dut8 (
        .clk(clk), .rst(rst), .input_valid(v8), .input_ready(ir8), .in(in8),
        .output_valid(ov8), .output_ready(or8), .out(out8), .occupancy(occ8));

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic apply_stimulus(input logic valid, input logic ready, input logic [31:0] din);
        @(negedge clk);
        v3  = valid;
        or3 = ready;
        in3 = din;
        #1;
    endtask

    vec_t  vecs [10];
    item_t q [$];

    initial begin
        logic exp_ov;
        logic exp_ir;

        v2 = 1'b0; or2 = 1'b1; in2 = '0;
        v3 = 1'b0; or3 = 1'b1; in3 = '0;
        v8 = 1'b0; or8 = 1'b1; in8 = '0;

        // Full-stall then drain on the 3-stage MODE 1 pipe (CONST 42).
        vecs[0] = '{1'b1, 1'b0, 32'd100, 1'b0, 32'd0,   2'd0, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 32'd101, 1'b0, 32'd0,   2'd1, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 32'd102, 1'b0, 32'd0,   2'd2, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 32'd103, 1'b1, 32'd142, 2'd3, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'd103, 1'b1, 32'd142, 2'd3, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 32'd103, 1'b1, 32'd142, 2'd3, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 32'd0,   1'b1, 32'd143, 2'd3, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 32'd0,   1'b1, 32'd144, 2'd2, 1'b1};
        vecs[8] = '{1'b0, 1'b1, 32'd0,   1'b1, 32'd145, 2'd1, 1'b1};
        vecs[9] = '{1'b0, 1'b0, 32'd0,   1'b0, 32'd145, 2'd0, 1'b1};

        apply_reset();

        // Idle after reset.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            check_output("idle_ov",  32'(ov2),  32'd0);
            check_output("idle_out", out2,      32'd0);
            check_output("idle_occ", 32'(occ2), 32'd0);
            check_output("idle_ir",  32'(ir2),  32'd1);
        end

        // MODE 0 single pulse: one output cycle, two cycles later.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            v2 = (k == 0);
            #1;
            check_output("m0_pulse_ov", 32'(ov2), (k == 2) ? 32'd1 : 32'd0);
            if (k == 2) check_output("m0_pulse_out", out2, 32'h2a);
        end
        v2 = 1'b0;

        apply_reset();

        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i].valid, vecs[i].ready, vecs[i].din);
            check_output($sformatf("vec%0d_ov", i),  32'(ov3),  32'(vecs[i].ov));
            check_output($sformatf("vec%0d_out", i), out3,      vecs[i].dout);
            check_output($sformatf("vec%0d_occ", i), 32'(occ3), 32'(vecs[i].occ));
            check_output($sformatf("vec%0d_ir", i),  32'(ir3),  32'(vecs[i].ir));
        end

        // Back-to-back stream 0..9: 42..51 with 3-cycle latency and no gaps.
        for (int k = 0; k < 14; k++) begin
            apply_stimulus(k < 10, 1'b1, 32'(k));
            check_output("stream_ov", 32'(ov3), (k >= 3 && k <= 12) ? 32'd1 : 32'd0);
            if (k >= 3 && k <= 12) check_output("stream_out", out3, 32'(k - 3 + 42));
        end

        // 8-bit wrap: F8 + 10 = 08.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            v8  = (k == 0);
            in8 = 8'hF8;
            #1;
            check_output("wrap_ov", 32'(ov8), (k == 2) ? 32'd1 : 32'd0);
            if (k == 2) check_output("wrap_out", 32'(out8), 32'h08);
        end
        v8 = 1'b0;

        // Fill, then asynchronous reset between clock edges.
        for (int k = 0; k < 3; k++) apply_stimulus(1'b1, 1'b0, 32'(k + 1));
        apply_stimulus(1'b1, 1'b0, 32'd9);
        check_output("full_occ", 32'(occ3), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check_output("areset_ov",  32'(ov3),  32'd0);
        check_output("areset_occ", 32'(occ3), 32'd0);
        check_output("areset_ir",  32'(ir3),  32'd1);
        v3 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(k == 0, 1'b1, 32'd7);
            check_output("post_rst_ov", 32'(ov3), (k == 3) ? 32'd1 : 32'd0);
            if (k == 3) check_output("post_rst_out", out3, 32'd49);
        end

        // Random valid/ready against a FIFO scoreboard.
        apply_reset();
        q.delete();
        for (int n = 0; n < 4000; n++) begin
            apply_stimulus(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 7), $urandom);
            exp_ov = (q.size() > 0) && (q[0].cyc + 3 <= n);
            exp_ir = (q.size() < 3) || or3;
            check_output("rand_ov",  32'(ov3),  32'(exp_ov));
            check_output("rand_ir",  32'(ir3),  32'(exp_ir));
            check_output("rand_occ", 32'(occ3), 32'(q.size()));
            if (exp_ov) check_output("rand_out", out3, q[0].val);
            if (exp_ov && or3) void'(q.pop_front());
            if (v3 && exp_ir) q.push_back('{in3 + 32'd42, n});
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
